// File: rtl/sub_bytes_sched.sv
// sub_bytes_sched: shares one 32-bit four-byte S-box unit between the key
// expander (one word per request) and the cipher round (four words per request).
// Ports: clk, rst_n (async, active low);
//   key_req/key_word -> key_ack, key_out, key_done;
//   st_req/st_in -> st_ack, st_out, st_done;
//   sbox_in -> external S-box -> sbox_out; busy = not IDLE.
// Config: SBOX_SCHED_RR_EN selects round-robin arbitration instead of key-first.
module sub_bytes_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_req,
  input  logic [31:0]  key_word,
  output logic         key_ack,
  output logic [31:0]  key_out,
  output logic         key_done,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_ack,
  output logic [127:0] st_out,
  output logic         st_done,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEY,
    S_ST
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   wc_q, wc_d;
  logic [127:0] cap_q, cap_d;
  logic [127:0] res_q, res_d;
  logic [127:0] st_out_q, st_out_d;
  logic [31:0]  key_out_q, key_out_d;
  logic         key_done_q, key_done_d;
  logic         st_done_q, st_done_d;
  logic         grant_key, grant_st;
  logic         idle;
  logic [6:0]   slice;

  assign idle  = (state_q == S_IDLE);
  // wc=0 addresses the top word [127:96], wc=3 the bottom word [31:0]
  assign slice = {~wc_q, 5'd0};

`ifdef SBOX_SCHED_RR_EN
  // last_q: 1 = state requester was granted last
  logic last_q, last_d;

  always_comb begin
    grant_key = key_req & (~st_req | last_q);
    grant_st  = st_req & (~key_req | ~last_q);
  end

  always_comb begin
    last_d = last_q;
    if (key_ack) last_d = 1'b0;
    if (st_ack)  last_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  always_comb begin
    grant_key = key_req;
    grant_st  = st_req & ~key_req;
  end
`endif

  // acks are forced low while reset is held
  assign key_ack = rst_n & idle & grant_key;
  assign st_ack  = rst_n & idle & grant_st;

  always_comb begin
    sbox_in = '0;
    unique case (state_q)
      S_KEY:   sbox_in = cap_q[127:96];
      S_ST:    sbox_in = cap_q[slice +: 32];
      default: sbox_in = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wc_d       = wc_q;
    cap_d      = cap_q;
    res_d      = res_q;
    st_out_d   = st_out_q;
    key_out_d  = key_out_q;
    key_done_d = 1'b0;
    st_done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          key_ack: begin
            cap_d   = {key_word, 96'd0};
            state_d = S_KEY;
          end
          st_ack: begin
            cap_d   = st_in;
            wc_d    = 2'd0;
            state_d = S_ST;
          end
          default: ;
        endcase
      end
      S_KEY: begin
        key_out_d  = sbox_out;
        key_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_ST: begin
        res_d[slice +: 32] = sbox_out;
        wc_d = wc_q + 2'd1;
        if (wc_q == 2'd3) begin
          st_out_d  = {res_q[127:32], sbox_out};
          st_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wc_q       <= 2'd0;
      cap_q      <= '0;
      res_q      <= '0;
      st_out_q   <= '0;
      key_out_q  <= '0;
      key_done_q <= 1'b0;
      st_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wc_q       <= wc_d;
      cap_q      <= cap_d;
      res_q      <= res_d;
      st_out_q   <= st_out_d;
      key_out_q  <= key_out_d;
      key_done_q <= key_done_d;
      st_done_q  <= st_done_d;
    end
  end

  assign key_out  = key_out_q;
  assign key_done = key_done_q;
  assign st_out   = st_out_q;
  assign st_done  = st_done_q;
  assign busy     = ~idle;

endmodule

// File: tb/tb_sub_bytes_sched.sv
// tb_sub_bytes_sched: scoreboard bench for sub_bytes_sched.
// Behavioural S-box (GF(2^8) inverse + affine) feeds the DUT and the model.
module tb_sub_bytes_sched;

  logic         clk;
  logic         rst_n;
  logic         key_req;
  logic [31:0]  key_word;
  logic         key_ack;
  logic [31:0]  key_out;
  logic         key_done;
  logic         st_req;
  logic [127:0] st_in;
  logic         st_ack;
  logic [127:0] st_out;
  logic         st_done;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic         busy;

  sub_bytes_sched dut (
    .clk(clk), .rst_n(rst_n),
    .key_req(key_req), .key_word(key_word),
    .key_ack(key_ack), .key_out(key_out), .key_done(key_done),
    .st_req(st_req), .st_in(st_in),
    .st_ack(st_ack), .st_out(st_out), .st_done(st_done),
    .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'd0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'd0;
    for (int b = 1; b < 256; b++)
      if (a != 8'd0 && gmul(a, 8'(b)) == 8'd1) inv = 8'(b);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
               ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] s);
    return {subw(s[127:96]), subw(s[95:64]), subw(s[63:32]), subw(s[31:0])};
  endfunction

  assign sbox_out = subw(sbox_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] val;
    int           due;
  } exp_t;

  exp_t         kq[$];
  exp_t         sq[$];
  int           free_cyc;
  int           acc_cyc;
  bit           cur_key;
  logic [127:0] cur_data;
  bit           last_st;
  logic [31:0]  key_out_exp;
  logic [127:0] st_out_exp;
  bit           key_acked;
  bit           st_acked;

  task automatic model_reset();
    kq.delete();
    sq.delete();
    free_cyc    = 0;
    last_st     = 1'b1;
    key_out_exp = '0;
    st_out_exp  = '0;
    key_acked   = 1'b0;
    st_acked    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      bit          idle, exp_k, exp_s, kd, sd;
      logic [31:0] sbx;
      int          idx;
      idle  = (cyc >= free_cyc);
      exp_k = 1'b0;
      exp_s = 1'b0;
      if (idle) begin
        if (key_req && st_req) begin
`ifdef SBOX_SCHED_RR_EN
          if (last_st) exp_k = 1'b1;
          else         exp_s = 1'b1;
`else
          exp_k = 1'b1;
`endif
        end else begin
          exp_k = key_req;
          exp_s = st_req;
        end
      end
      chk("key_ack", 128'(key_ack), 128'(exp_k));
      chk("st_ack", 128'(st_ack), 128'(exp_s));
      chk("busy", 128'(busy), 128'(!idle));
      sbx = '0;
      if (!idle) begin
        idx = cyc - acc_cyc - 1;
        if (cur_key) sbx = cur_data[127:96];
        else         sbx = cur_data[(3 - idx) * 32 +: 32];
      end
      chk("sbox_in", 128'(sbox_in), 128'(sbx));
      kd = (kq.size() > 0) && (kq[0].due == cyc);
      sd = (sq.size() > 0) && (sq[0].due == cyc);
      chk("key_done", 128'(key_done), 128'(kd));
      chk("st_done", 128'(st_done), 128'(sd));
      if (kd) begin
        key_out_exp = kq[0].val[31:0];
        void'(kq.pop_front());
      end
      if (sd) begin
        st_out_exp = sq[0].val;
        void'(sq.pop_front());
      end
      chk("key_out", 128'(key_out), 128'(key_out_exp));
      chk("st_out", st_out, st_out_exp);
      if (exp_k) begin
        kq.push_back('{val: 128'(subw(key_word)), due: cyc + 2});
        free_cyc = cyc + 2;
        acc_cyc  = cyc;
        cur_key  = 1'b1;
        cur_data = {key_word, 96'd0};
        last_st  = 1'b0;
      end
      if (exp_s) begin
        sq.push_back('{val: sub128(st_in), due: cyc + 5});
        free_cyc = cyc + 5;
        acc_cyc  = cyc;
        cur_key  = 1'b0;
        cur_data = st_in;
        last_st  = 1'b1;
      end
      key_acked = exp_k;
      st_acked  = exp_s;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_key_ack"}, 128'(key_ack), 128'(0));
    chk({tag, "_st_ack"}, 128'(st_ack), 128'(0));
    chk({tag, "_key_done"}, 128'(key_done), 128'(0));
    chk({tag, "_st_done"}, 128'(st_done), 128'(0));
    chk({tag, "_key_out"}, 128'(key_out), 128'(0));
    chk({tag, "_st_out"}, st_out, 128'(0));
    chk({tag, "_sbox_in"}, 128'(sbox_in), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  localparam logic [127:0] VEC_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  int nk, ns;

  initial begin
    rst_n = 1'b1; key_req = 1'b0; st_req = 1'b0;
    key_word = '0; st_in = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // key only
    key_req = 1'b1; key_word = 32'h0;
    @(negedge clk);
    chk("key_ack_dir", 128'(key_ack), 128'(1));
    tick(); key_req = 1'b0;
    repeat (3) tick();
    chk("key_vec", 128'(key_out), 128'(32'h63636363));

    // state only
    st_req = 1'b1; st_in = VEC_IN;
    tick(); st_req = 1'b0;
    repeat (6) tick();
    chk("st_vec", st_out, VEC_OUT);

    // contention, both held
    key_req = 1'b1; key_word = 32'h53535353;
    st_req = 1'b1; st_in = {$urandom, $urandom, $urandom, $urandom};
    nk = 0; ns = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nk += int'(key_ack);
      ns += int'(st_ack);
      tick();
    end
    key_req = 1'b0; st_req = 1'b0;
    repeat (6) tick();
`ifdef SBOX_SCHED_RR_EN
    chk("cont_key_acks", 128'(nk), 128'(2));
    chk("cont_st_acks", 128'(ns), 128'(2));
`else
    chk("cont_key_acks", 128'(nk), 128'(6));
    chk("cont_st_acks", 128'(ns), 128'(0));
`endif
    chk("cont_key_out", 128'(key_out), 128'(32'hedededed));

    // back-to-back state requests
    st_req = 1'b1; st_in = {$urandom, $urandom, $urandom, $urandom};
    ns = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ns += int'(st_ack);
      tick();
    end
    st_req = 1'b0;
    repeat (6) tick();
    chk("b2b_st_acks", 128'(ns), 128'(2));

    // reset in the middle of a state transfer
    st_req = 1'b1; st_in = {$urandom, $urandom, $urandom, $urandom};
    tick(); st_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_zero("abort");
    tick(); tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("abort_st_out", st_out, 128'(0));
    st_req = 1'b1; st_in = VEC_IN;
    tick(); st_req = 1'b0;
    repeat (6) tick();
    chk("post_abort_st", st_out, VEC_OUT);

    // key request withdrawn while busy
    st_req = 1'b1; st_in = {$urandom, $urandom, $urandom, $urandom};
    tick(); st_req = 1'b0;
    nk = 0;
    for (int i = 0; i < 6; i++) begin
      key_req = (i == 1);
      key_word = $urandom;
      @(negedge clk);
      nk += int'(key_ack) + int'(key_done);
      tick();
    end
    key_req = 1'b0;
    chk("withdraw_key", 128'(nk), 128'(0));
    repeat (3) tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (key_acked || !key_req) begin
        key_req  = ($urandom_range(0, 2) == 0);
        key_word = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        key_req = 1'b0;
      end
      if (st_acked || !st_req) begin
        st_req = ($urandom_range(0, 2) == 0);
        st_in  = {$urandom, $urandom, $urandom, $urandom};
      end else if ($urandom_range(0, 7) == 0) begin
        st_req = 1'b0;
      end
      tick();
    end
    key_req = 1'b0; st_req = 1'b0;
    repeat (8) tick();
    chk("drain", 128'(kq.size() + sq.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_bytes_sched.md
# sub_bytes_sched

Time-multiplexing scheduler for the single 32-bit four-byte S-box unit in the AES datapath. It arbitrates between the key expander (one 32-bit SubWord per request) and the cipher round (one 128-bit SubBytes per request). A 128-bit state is fed through the unit one word per cycle and the result is reassembled. The S-box unit itself is external and purely combinational; this block drives its input and samples its output.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_req  in  1  key-expander request (level)
- key_word  in  32  word to substitute; sampled on the key_ack cycle
- key_ack  out  1  combinational; high in the cycle the key request is accepted
- key_out  out  32  substituted word; valid while key_done=1, held afterwards
- key_done  out  1  one-cycle result pulse
- st_req  in  1  cipher-round request (level)
- st_in  in  128  state to substitute; sampled on the st_ack cycle
- st_ack  out  1  combinational; high in the cycle the state request is accepted
- st_out  out  128  substituted state; valid while st_done=1, held afterwards
- st_done  out  1  one-cycle result pulse
- sbox_in  out  32  drive to the S-box unit
- sbox_out  in  32  combinational result from the S-box unit
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, KEY, ST (2-bit word counter wc).
- IDLE:
  - Grant per arbitration (below); assert the matching ack and capture the request data into an internal register.
  - Key grant goes to KEY; state grant goes to ST with wc=0. No request: stay in IDLE.
- KEY: sbox_in = captured word. At the clock edge, key_out <= sbox_out, key_done <= 1, state goes to IDLE.
- ST:
  - sbox_in = captured state word wc, where wc=0 selects bits [127:96] and wc=3 selects bits [31:0].
  - At each edge, sbox_out is written to the same slice of the result register and wc increments.
  - At wc=3: st_out <= the full result, st_done <= 1, state goes to IDLE.
- sbox_in is 0 in IDLE.
- Acks are asserted only in IDLE. At most one ack is high in any cycle.
- A requester that is not acked keeps its req high. Deasserting req before ack withdraws the request, with no side effect.
- A held req after done is treated as a new request.
- Default arbitration is fixed priority, key first: a continuous key_req may starve st_req.

## Timing
- Accept at cycle N: key_done is high in N+2; st_done is high in N+5.
- In the done cycle the FSM is already in IDLE and can accept a new request in that same cycle (back-to-back throughput: key 1 request / 2 cycles, state 1 request / 5 cycles).
- Simultaneous key_req and st_req in IDLE: resolved by arbitration. The loser waits; its ack arrives in the winner's done cycle at the earliest.
- Reset values: key_ack=0, st_ack=0, key_done=0, st_done=0, key_out=0, st_out=0, sbox_in=0, busy=0, state=IDLE, wc=0, last-grant=state.
- Reset mid-operation aborts the transfer immediately. No done pulse is produced and partial results are discarded (st_out returns to 0).
- Requests arriving while busy are ignored until IDLE. They are not queued.

## Configuration
- SBOX_SCHED_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant register is updated on every grant; on contention the requester not granted last wins.
  - Reset value is "state", so the key expander wins first contention after reset.
  - A single requester is always granted immediately.
- SBOX_SCHED_RR_EN undefined: fixed key-first priority; the last-grant register is not built.

## Test plan
- Key only: key_word=0x00000000 with key_req for one cycle -> key_ack that cycle; key_done 2 cycles later with key_out=0x63636363; busy high for 1 cycle.
- State only: st_in=0x00112233445566778899aabbccddeeff -> st_done 5 cycles after ack with st_out=0x638293c31bfc33f5c4eeacea4bc12816. sbox_in steps through 0x00112233, 0x44556677, 0x8899aabb, 0xccddeeff.
- Contention: key_req and st_req both high and held, key_word=0x53535353.
  - Fixed priority: key wins repeatedly, key_out=0xedededed, and st_ack never occurs.
  - With SBOX_SCHED_RR_EN: grants alternate key, state, key, and so on.
- Back-to-back: st_req held for two requests -> second st_ack coincides with the first st_done; two done pulses 5 cycles apart.
- Reset abort: assert rst_n=0 two cycles after st_ack -> all outputs 0 asynchronously; no st_done after release; the next request completes normally.
- Withdrawn request: key_req pulses while busy in ST and drops before IDLE -> no key_ack and no key_done.
